// File: rtl/icache_refill_ctrl_pkg.sv
// rtl/icache_refill_ctrl_pkg.sv - shared types and constants for the I-cache refill controller
//
// Purpose: refill FSM state encoding and default geometry shared by the
// refill controller and its line buffer.
// Contents: refillState_t (IDLE/REQ/RESP/WRITE), default widths, and the
// line-offset and beat-counter widths derived from the default geometry.
package icache_refill_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    RESP  = 2'd2,
    WRITE = 2'd3
  } refillState_t;

  localparam int DEF_ADDR_W     = 32;
  localparam int DEF_LINE_BYTES = 32;
  localparam int DEF_BEAT_W     = 64;

  // Derived from the default geometry; the top re-derives these from its own
  // parameters so that overridden instances stay consistent.
  localparam int LINE_OFF_W = $clog2(DEF_LINE_BYTES);
  localparam int BEAT_CNT_W = $clog2((DEF_LINE_BYTES * 8) / DEF_BEAT_W);

endpackage

// File: rtl/icache_refill_ctrl_refill_line_buffer.sv
// rtl/icache_refill_ctrl_refill_line_buffer.sv - beat-indexed line assembly buffer
//
// Purpose: stores response beats into a LINE_W register, beat 0 in the least
// significant slot, and tracks the beat index.
// Ports:
//   clk, reset      clock, synchronous active-high reset (clears buffer and counter)
//   clear           restart the beat counter at 0 (new refill)
//   beatValid       store beatData at the current beat slot and advance
//   beatData        response beat
//   lineData        assembled line
//   lastBeat        combinational: the beat being accepted fills the final slot
module refill_line_buffer
  import icache_refill_ctrl_pkg::*;
#(
  parameter int BEAT_W = DEF_BEAT_W,
  parameter int BEATS  = 4,
  parameter int CNT_W  = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clear,
  input  logic                      beatValid,
  input  logic [BEAT_W-1:0]         beatData,
  output logic [BEAT_W*BEATS-1:0]   lineData,
  output logic                      lastBeat
);

  logic [CNT_W-1:0] beatCnt;

  assign lastBeat = beatValid && (beatCnt == CNT_W'(BEATS - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      beatCnt  <= '0;
      lineData <= '0;
    end else if (clear) begin
      beatCnt <= '0;
    end else if (beatValid) begin
      // Wrap explicitly on the last beat so the next refill starts at slot 0.
      beatCnt <= lastBeat ? '0 : beatCnt + CNT_W'(1);
      for (int b = 0; b < BEATS; b++) begin
        if (beatCnt == CNT_W'(b)) begin
          lineData[b*BEAT_W +: BEAT_W] <= beatData;
        end
      end
    end
  end

endmodule

// File: rtl/icache_refill_ctrl.sv
// rtl/icache_refill_ctrl.sv - L1 I-cache miss handler: one line request, beat collection, line install
//
// Purpose: on an I-cache miss, requests the aligned line from lower memory,
// assembles the multi-beat response and writes the line into the cache with
// a one-cycle strobe. Stalls fetch while a refill is in flight.
// Optional: define ICACHE_REFILL_STATS_EN to add refill / stall counters.
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   miss_i, missAddr_i              miss flag and missing address from the I-cache
//   memReqValid_o/Ready_i/Addr_o    line request handshake
//   memRespValid_i/Data_i/Err_i     response beats
//   wrEnable_o, wrAddr_o, instBlock_o  cache line write
//   refillBusy_o                    fetch stall
//   refillErr_o                     one-cycle pulse when a refill is dropped on error
//   refillCount_o, stallCycles_o    (ICACHE_REFILL_STATS_EN only) saturating counters
module icache_refill_ctrl
  import icache_refill_ctrl_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int LINE_BYTES = DEF_LINE_BYTES,
  parameter int BEAT_W     = DEF_BEAT_W,
  parameter int LINE_W     = LINE_BYTES * 8,
  parameter int BEATS      = LINE_W / BEAT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              miss_i,
  input  logic [ADDR_W-1:0] missAddr_i,
  output logic              memReqValid_o,
  input  logic              memReqReady_i,
  output logic [ADDR_W-1:0] memReqAddr_o,
  input  logic              memRespValid_i,
  input  logic [BEAT_W-1:0] memRespData_i,
  input  logic              memRespErr_i,
  output logic              wrEnable_o,
  output logic [ADDR_W-1:0] wrAddr_o,
  output logic [LINE_W-1:0] instBlock_o,
  output logic              refillBusy_o,
`ifdef ICACHE_REFILL_STATS_EN
  output logic [31:0]       refillCount_o,
  output logic [31:0]       stallCycles_o,
`endif
  output logic              refillErr_o
);

  localparam int OFF_W = $clog2(LINE_BYTES);
  localparam int CNT_W = $clog2(BEATS);
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((64'd1 << OFF_W) - 64'd1);

  refillState_t      state;
  logic [ADDR_W-1:0] lineAddr;
  logic              errFlag;
  logic              reqFire;
  logic              beatValid;
  logic              lastBeat;

  assign reqFire   = (state == REQ) && memReqReady_i;
  // Beats are only meaningful while waiting for the response.
  assign beatValid = (state == RESP) && memRespValid_i;

  // The request and write addresses are both the latched line address.
  assign memReqAddr_o = lineAddr;
  assign wrAddr_o     = lineAddr;

  refill_line_buffer #(
    .BEAT_W (BEAT_W),
    .BEATS  (BEATS),
    .CNT_W  (CNT_W)
  ) u_lineBuf (
    .clk       (clk),
    .reset     (reset),
    .clear     (reqFire),
    .beatValid (beatValid),
    .beatData  (memRespData_i),
    .lineData  (instBlock_o),
    .lastBeat  (lastBeat)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      lineAddr      <= '0;
      errFlag       <= 1'b0;
      memReqValid_o <= 1'b0;
      wrEnable_o    <= 1'b0;
      refillBusy_o  <= 1'b0;
      refillErr_o   <= 1'b0;
    end else begin
      wrEnable_o  <= 1'b0;
      refillErr_o <= 1'b0;
      case (state)
        IDLE: begin
          if (miss_i) begin
            lineAddr      <= missAddr_i & ~OFF_MASK;
            memReqValid_o <= 1'b1;
            refillBusy_o  <= 1'b1;
            state         <= REQ;
          end
        end
        REQ: begin
          if (memReqReady_i) begin
            memReqValid_o <= 1'b0;
            errFlag       <= 1'b0;
            state         <= RESP;
          end
        end
        RESP: begin
          if (memRespValid_i) begin
            if (memRespErr_i) begin
              errFlag <= 1'b1;
            end
            if (lastBeat) begin
              // The current beat's error counts too; it is not in errFlag yet.
              if (errFlag || memRespErr_i) begin
                refillErr_o  <= 1'b1;
                refillBusy_o <= 1'b0;
                state        <= IDLE;
              end else begin
                wrEnable_o <= 1'b1;
                state      <= WRITE;
              end
            end
          end
        end
        WRITE: begin
          refillBusy_o <= 1'b0;
          state        <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef ICACHE_REFILL_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      refillCount_o <= '0;
      stallCycles_o <= '0;
    end else begin
      if (reqFire && (refillCount_o != '1)) begin
        refillCount_o <= refillCount_o + 32'd1;
      end
      if (refillBusy_o && (stallCycles_o != '1)) begin
        stallCycles_o <= stallCycles_o + 32'd1;
      end
    end
  end
`endif

endmodule
